// File: rtl/udp_tx_sched.sv
// ---------------------------------------------------------------------------
// udp_tx_sched
//
// Two-channel transmit scheduler for the UDP engine (eth_tx_clk domain).
// Channel 0 is the receive-echo FIFO path, channel 1 the local status /
// heartbeat source. Each channel posts a one-cycle start pulse with a byte
// count. The request is latched as "pending" and the single UDP transmitter
// is granted round-robin. While a packet is in flight the engine's data
// request is steered to the granted channel's source and that source's data
// is steered back to the engine. After each packet a minimum idle gap is
// enforced. A watchdog aborts a packet whose tx_done never arrives.
//
// Ports
//   eth_tx_clk     in   clock
//   rst            in   asynchronous, active-high reset
//   ch0_start      in   one-cycle send request, channel 0
//   ch0_byte_num   in   [15:0] payload bytes, sampled with ch0_start
//   ch0_rd_en      out  read strobe to channel 0 data source
//   ch0_rd_data    in   [31:0] data from channel 0 source
//   ch0_done       out  one-cycle pulse, channel 0 packet completed
//   ch1_*          same set for channel 1
//   tx_start_en    out  one-cycle start pulse to the UDP engine
//   tx_byte_num    out  [15:0] byte count to the engine, changes only on grant
//   tx_req         in   engine data request
//   tx_data        out  [31:0] data to the engine
//   tx_done        in   engine completion pulse
//   busy           out  high whenever the scheduler is not idle
//   active_ch      out  channel currently or last granted
//   timeout_err    out  one-cycle pulse when a packet is aborted
//   dbg_state      out  [1:0] current FSM state (0 IDLE,1 START,2 BUSY,3 GAP)
//
// Data handshake with the engine: the engine raises tx_req in every cycle it
// consumes a word. In BUSY, tx_req is forwarded in the same cycle as rd_en to
// the granted channel's source, and that source's rd_data is presented on
// tx_data. There is no back-pressure toward the engine: the source must be
// able to supply a word in every cycle rd_en is high. tx_req and tx_done seen
// outside BUSY have no effect.
// ---------------------------------------------------------------------------
module udp_tx_sched #(
   parameter int GAP_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        eth_tx_clk,
   input  logic        rst,
   input  logic        ch0_start,
   input  logic [15:0] ch0_byte_num,
   output logic        ch0_rd_en,
   input  logic [31:0] ch0_rd_data,
   output logic        ch0_done,
   input  logic        ch1_start,
   input  logic [15:0] ch1_byte_num,
   output logic        ch1_rd_en,
   input  logic [31:0] ch1_rd_data,
   output logic        ch1_done,
   output logic        tx_start_en,
   output logic [15:0] tx_byte_num,
   input  logic        tx_req,
   output logic [31:0] tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        active_ch,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   // Gap counter width; at least one bit so GAP_CYCLES = 0 still elaborates.
   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   // Watchdog value at which BUSY is abandoned.
   localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t           state;
   logic             pend0;
   logic             pend1;
   logic [15:0]      len0;
   logic [15:0]      len1;
   logic             rr;        // channel favoured when both are pending
   logic [23:0]      wd_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic grant_ok;
   logic grant_ch;

   // ------------------------------------------------------------------------
   // Grant decision. With a single pending channel it wins outright; with
   // both pending the rr bit decides. rr always points away from the channel
   // just served, so a lone request does not cost the other channel its turn.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_ok = 1'b0;
      grant_ch = 1'b0;
      if (state == S_IDLE && (pend0 || pend1)) begin
         grant_ok = 1'b1;
         if (pend0 && pend1) begin
            grant_ch = rr;
         end else begin
            grant_ch = pend1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pending latches. A new non-zero request always wins over the clear from
   // a grant in the same cycle, so a request arriving as its predecessor is
   // granted is kept as a fresh packet. Repeated requests while pending just
   // overwrite the length (coalescing). Zero-length requests are dropped.
   // ------------------------------------------------------------------------
   always_ff @(posedge eth_tx_clk or posedge rst) begin
      if (rst) begin
         pend0 <= 1'b0;
         pend1 <= 1'b0;
         len0  <= 16'd0;
         len1  <= 16'd0;
      end else begin
         if (ch0_start && ch0_byte_num != 16'd0) begin
            pend0 <= 1'b1;
            len0  <= ch0_byte_num;
         end else if (grant_ok && !grant_ch) begin
            pend0 <= 1'b0;
         end

         if (ch1_start && ch1_byte_num != 16'd0) begin
            pend1 <= 1'b1;
            len1  <= ch1_byte_num;
         end else if (grant_ok && grant_ch) begin
            pend1 <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Main FSM with registered pulse outputs.
   //   IDLE  -> START on grant (latch channel, byte count, advance rr)
   //   START -> BUSY, raising tx_start_en for the first BUSY cycle
   //   BUSY  -> GAP on tx_done (done pulse) or watchdog expiry (error pulse);
   //            tx_done is checked first so it wins a tie with the watchdog
   //   GAP   -> IDLE after GAP_CYCLES + 1 cycles
   // ------------------------------------------------------------------------
   always_ff @(posedge eth_tx_clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         rr          <= 1'b0;
         active_ch   <= 1'b0;
         tx_byte_num <= 16'd0;
         tx_start_en <= 1'b0;
         ch0_done    <= 1'b0;
         ch1_done    <= 1'b0;
         timeout_err <= 1'b0;
         wd_cnt      <= 24'd0;
         gap_cnt     <= '0;
      end else begin
         tx_start_en <= 1'b0;
         ch0_done    <= 1'b0;
         ch1_done    <= 1'b0;
         timeout_err <= 1'b0;

         case (state)
            S_IDLE: begin
               if (grant_ok) begin
                  active_ch   <= grant_ch;
                  tx_byte_num <= grant_ch ? len1 : len0;
                  rr          <= ~grant_ch;
                  state       <= S_START;
               end
            end

            S_START: begin
               tx_start_en <= 1'b1;
               wd_cnt      <= 24'd0;
               state       <= S_BUSY;
            end

            S_BUSY: begin
               if (tx_done) begin
                  if (active_ch) begin
                     ch1_done <= 1'b1;
                  end else begin
                     ch0_done <= 1'b1;
                  end
                  gap_cnt <= GAP_LOAD;
                  state   <= S_GAP;
               end else if (wd_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  gap_cnt     <= GAP_LOAD;
                  state       <= S_GAP;
               end else begin
                  wd_cnt <= wd_cnt + 24'd1;
               end
            end

            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath steering. Read strobes only exist in BUSY so a stray tx_req
   // during START or GAP cannot pop a word from either source.
   // ------------------------------------------------------------------------
   always_comb begin
      ch0_rd_en = tx_req && (state == S_BUSY) && !active_ch;
      ch1_rd_en = tx_req && (state == S_BUSY) && active_ch;
      tx_data   = active_ch ? ch1_rd_data : ch0_rd_data;
      busy      = (state != S_IDLE);
      dbg_state = state;
   end

endmodule

// File: tb/tb_udp_tx_sched.sv
`timescale 1ns/1ps
module tb_udp_tx_sched;

   localparam int GAP = 12;
   localparam int TMO = 100;

   // ---------------------------------------------------------------- clock/reset
   logic        eth_tx_clk = 1'b0;
   logic        rst;
   logic        ch0_start, ch1_start;
   logic [15:0] ch0_byte_num, ch1_byte_num;
   logic        ch0_rd_en, ch1_rd_en;
   logic [31:0] ch0_rd_data, ch1_rd_data;
   logic        ch0_done, ch1_done;
   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic        tx_req;
   logic [31:0] tx_data;
   logic        tx_done;
   logic        busy;
   logic        active_ch;
   logic        timeout_err;
   logic [1:0]  dbg_state;

   always #5 eth_tx_clk = ~eth_tx_clk;

   udp_tx_sched #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .eth_tx_clk  (eth_tx_clk),
      .rst         (rst),
      .ch0_start   (ch0_start),
      .ch0_byte_num(ch0_byte_num),
      .ch0_rd_en   (ch0_rd_en),
      .ch0_rd_data (ch0_rd_data),
      .ch0_done    (ch0_done),
      .ch1_start   (ch1_start),
      .ch1_byte_num(ch1_byte_num),
      .ch1_rd_en   (ch1_rd_en),
      .ch1_rd_data (ch1_rd_data),
      .ch1_done    (ch1_done),
      .tx_start_en (tx_start_en),
      .tx_byte_num (tx_byte_num),
      .tx_req      (tx_req),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .active_ch   (active_ch),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];     // expected packets {15'b0, channel, byte count}
   bit          sb_on    = 1'b0;
   bit          auto_eng = 1'b0;
   int          eng_delay = 5;
   int          eng_cnt   = 0;
   int          start_seen = 0;
   int          done0 = 0, done1 = 0, to_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   // Advance one clock; on return we sit 1ns after the rising edge.
   task automatic cyc();
      @(posedge eth_tx_clk);
      #1;
      ch0_start = 1'b0;
      ch1_start = 1'b0;
      tx_done   = 1'b0;
      if (tx_start_en) begin
         start_seen++;
         if (sb_on) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pkt_extra: got ch=%0d len=%0d, none expected", active_ch, tx_byte_num);
            end else begin
               chk("pkt", {15'd0, active_ch, tx_byte_num}, exp_q.pop_front());
            end
         end
      end
      if (ch0_done) done0++;
      if (ch1_done) done1++;
      if (timeout_err) to_cnt++;
      if (auto_eng) begin
         if (tx_start_en) begin
            eng_cnt = eng_delay;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) tx_done = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ch0_start = 1'b0; ch1_start = 1'b0;
      ch0_byte_num = 16'd0; ch1_byte_num = 16'd0;
      ch0_rd_data = 32'd0; ch1_rd_data = 32'd0;
      tx_req = 1'b0; tx_done = 1'b0;
      eng_cnt = 0;
      repeat (2) @(posedge eth_tx_clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_start(input string name);
      int waited;
      waited = 0;
      while (!tx_start_en && waited < 10) begin
         cyc();
         waited++;
      end
      chk({name, "_start_seen"}, tx_start_en, 1);
      chk({name, "_start_lat"}, waited, 3);
   endtask

   // ---------------------------------------------------------------- vector table
   typedef struct {
      logic        s0;
      logic [15:0] l0;
      logic        s1;
      logic [15:0] l1;
      int          n;
      logic        ca;
      logic [15:0] ba;
      logic        cb;
      logic [15:0] bb;
   } row_t;
   row_t rows[10];

   // random-phase reference model state
   int          e, g, s_edge, end_edge, idle_edge, dsel, k, d0, d1, s0c;
   bit          have, m_to, m_rr, m_ch, busy_now;
   bit          mp[2];
   logic [15:0] ml[2];
   logic [15:0] m_len;
   logic        ps0, ps1;
   logic [15:0] pl0, pl1;
   bit          saw_rd1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rows[0] = '{1'b1, 16'd16, 1'b1, 16'd32,    2, 1'b0, 16'd16,  1'b1, 16'd32};
      rows[1] = '{1'b1, 16'd5,  1'b1, 16'd7,     2, 1'b0, 16'd5,   1'b1, 16'd7};
      rows[2] = '{1'b1, 16'd100,1'b1, 16'd200,   2, 1'b0, 16'd100, 1'b1, 16'd200};
      rows[3] = '{1'b0, 16'd0,  1'b1, 16'd9,     1, 1'b1, 16'd9,   1'b0, 16'd0};
      rows[4] = '{1'b1, 16'd3,  1'b1, 16'd4,     2, 1'b0, 16'd3,   1'b1, 16'd4};
      rows[5] = '{1'b1, 16'd0,  1'b1, 16'd0,     0, 1'b0, 16'd0,   1'b0, 16'd0};
      rows[6] = '{1'b1, 16'd64, 1'b0, 16'd0,     1, 1'b0, 16'd64,  1'b0, 16'd0};
      rows[7] = '{1'b1, 16'd10, 1'b1, 16'd11,    2, 1'b1, 16'd11,  1'b0, 16'd10};
      rows[8] = '{1'b1, 16'd0,  1'b1, 16'd6,     1, 1'b1, 16'd6,   1'b0, 16'd0};
      rows[9] = '{1'b1, 16'd1,  1'b1, 16'd65535, 2, 1'b0, 16'd1,   1'b1, 16'd65535};

      // ---------------- reset values
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_start", tx_start_en, 0);
      chk("rst_len", tx_byte_num, 0);
      chk("rst_ch", active_ch, 0);
      chk("rst_done0", ch0_done, 0);
      chk("rst_done1", ch1_done, 0);
      chk("rst_to", timeout_err, 0);
      chk("rst_state", dbg_state, 0);
      tx_req = 1'b1;
      #1;
      chk("rst_rd0", ch0_rd_en, 0);
      chk("rst_rd1", ch1_rd_en, 0);
      chk("rst_data", tx_data, 0);
      tx_req = 1'b0;

      // ---------------- single request, done 40 cycles after start
      ch0_byte_num = 16'd64; ch0_start = 1'b1;
      cyc();
      chk("sr_n_start", tx_start_en, 0);
      chk("sr_n_busy", busy, 0);
      cyc();
      chk("sr_n1_busy", busy, 1);
      chk("sr_n1_start", tx_start_en, 0);
      cyc();
      chk("sr_start", tx_start_en, 1);
      chk("sr_len", tx_byte_num, 64);
      chk("sr_ch", active_ch, 0);
      d0 = done0;
      saw_rd1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) cyc();
         tx_req = 1'($urandom_range(0, 1));
         ch0_rd_data = $urandom;
         ch1_rd_data = $urandom;
         if (i == 39) tx_done = 1'b1;
         #1;
         chk("sr_rd0", ch0_rd_en, tx_req);
         chk("sr_data", tx_data, ch0_rd_data);
         if (ch1_rd_en) saw_rd1 = 1'b1;
      end
      chk("sr_rd1_never", saw_rd1, 0);
      tx_req = 1'b0;
      cyc();
      chk("sr_done0", ch0_done, 1);
      chk("sr_done1", ch1_done, 0);
      chk("sr_to", timeout_err, 0);
      cyc();
      chk("sr_done0_pulse", ch0_done, 0);
      repeat (20) cyc();
      chk("sr_done_count", done0 - d0, 1);
      chk("sr_idle", busy, 0);

      // ---------------- table: simultaneous pairs and round-robin
      do_reset();
      sb_on = 1'b1; auto_eng = 1'b1; eng_delay = 5;
      for (int r = 0; r < 10; r++) begin
         d0 = done0; d1 = done1;
         if (rows[r].n > 0) exp_q.push_back({15'd0, rows[r].ca, rows[r].ba});
         if (rows[r].n > 1) exp_q.push_back({15'd0, rows[r].cb, rows[r].bb});
         ch0_start = rows[r].s0; ch0_byte_num = rows[r].l0;
         ch1_start = rows[r].s1; ch1_byte_num = rows[r].l1;
         repeat (60) cyc();
         chk($sformatf("row%0d_missing", r), exp_q.size(), 0);
         chk($sformatf("row%0d_dones", r), (done0 - d0) + (done1 - d1), rows[r].n);
         chk($sformatf("row%0d_idle", r), busy, 0);
         exp_q.delete();
      end

      // ---------------- coalescing while ch0 busy
      eng_delay = 40;
      d0 = done0; d1 = done1;
      exp_q.push_back({15'd0, 1'b0, 16'd50});
      exp_q.push_back({15'd0, 1'b1, 16'd20});
      ch0_byte_num = 16'd50; ch0_start = 1'b1;
      repeat (3) cyc();
      ch1_byte_num = 16'd8;  ch1_start = 1'b1;
      cyc(); cyc();
      ch1_byte_num = 16'd12; ch1_start = 1'b1;
      cyc();
      ch1_byte_num = 16'd20; ch1_start = 1'b1;
      repeat (130) cyc();
      chk("coal_missing", exp_q.size(), 0);
      chk("coal_done1", done1 - d1, 1);
      chk("coal_done0", done0 - d0, 1);
      exp_q.delete();

      // ---------------- zero length request
      s0c = start_seen; d0 = done0;
      ch0_byte_num = 16'd0; ch0_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("zero_busy", busy, 0);
      end
      chk("zero_starts", start_seen - s0c, 0);
      chk("zero_done", done0 - d0, 0);

      // ---------------- timeout
      sb_on = 1'b0; auto_eng = 1'b0;
      d0 = done0;
      ch0_byte_num = 16'd30; ch0_start = 1'b1;
      wait_start("to");
      k = 0;
      while (k < 150) begin
         cyc();
         k++;
         if (timeout_err) break;
      end
      chk("to_latency", k, TMO);
      chk("to_no_done", ch0_done, 0);
      for (int j = 1; j <= GAP + 1; j++) begin
         cyc();
         if (j == 1) chk("to_pulse", timeout_err, 0);
         chk($sformatf("to_gap%0d_busy", j), busy, (j <= GAP) ? 1 : 0);
      end
      chk("to_done_count", done0 - d0, 0);

      // ---------------- tx_done exactly at the watchdog limit
      ch0_byte_num = 16'd31; ch0_start = 1'b1;
      wait_start("tie");
      repeat (TMO - 1) cyc();
      tx_done = 1'b1;
      cyc();
      chk("tie_done0", ch0_done, 1);
      chk("tie_no_to", timeout_err, 0);
      cyc();
      chk("tie_no_to_late", timeout_err, 0);
      repeat (20) cyc();

      // ---------------- reset mid-packet with ch1 pending
      ch0_byte_num = 16'd40; ch0_start = 1'b1;
      wait_start("rm");
      ch1_byte_num = 16'd8; ch1_start = 1'b1;
      cyc(); cyc();
      tx_req = 1'b1;
      ch0_rd_data = 32'd0; ch1_rd_data = 32'hA5A5_5A5A;
      #1;
      chk("rm_pre_rd0", ch0_rd_en, 1);
      d0 = done0; d1 = done1; k = to_cnt; s0c = start_seen;
      rst = 1'b1;
      #1;
      chk("rm_busy", busy, 0);
      chk("rm_len", tx_byte_num, 0);
      chk("rm_ch", active_ch, 0);
      chk("rm_rd0", ch0_rd_en, 0);
      chk("rm_rd1", ch1_rd_en, 0);
      chk("rm_data", tx_data, 0);
      chk("rm_state", dbg_state, 0);
      tx_req = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         chk("rm_after_busy", busy, 0);
      end
      chk("rm_no_start", start_seen - s0c, 0);
      chk("rm_no_done", (done0 - d0) + (done1 - d1), 0);
      chk("rm_no_to", to_cnt - k, 0);
      ch1_byte_num = 16'd5; ch1_start = 1'b1;
      wait_start("rm_new");
      chk("rm_new_ch", active_ch, 1);
      chk("rm_new_len", tx_byte_num, 5);
      cyc();
      tx_done = 1'b1;
      repeat (20) cyc();

      // ---------------- randomized run against a timeline model
      do_reset();
      e = 0; have = 1'b0; m_rr = 1'b0; m_ch = 1'b0; m_len = 16'd0;
      mp[0] = 1'b0; mp[1] = 1'b0; ml[0] = 16'd0; ml[1] = 16'd0;
      ps0 = 1'b0; ps1 = 1'b0; pl0 = 16'd0; pl1 = 16'd0;
      g = 0; s_edge = 0; end_edge = 0; idle_edge = 0; dsel = 0; m_to = 1'b0;
      for (int it = 0; it < 3000; it++) begin
         cyc();
         e++;
         // Scheduler free at this edge: grant from requests latched earlier.
         if ((!have || e - 1 >= idle_edge) && (mp[0] || mp[1])) begin
            m_ch  = (mp[0] && mp[1]) ? m_rr : mp[1];
            m_len = ml[m_ch];
            mp[m_ch] = 1'b0;
            m_rr  = !m_ch;
            have  = 1'b1;
            g = e;
            s_edge = e + 1;
            dsel = ($urandom_range(0, 7) == 0) ? $urandom_range(95, 110) : $urandom_range(1, 25);
            m_to = (dsel > TMO);
            end_edge  = s_edge + (m_to ? TMO : dsel);
            idle_edge = end_edge + GAP + 1;
         end
         if (ps0 && pl0 != 16'd0) begin mp[0] = 1'b1; ml[0] = pl0; end
         if (ps1 && pl1 != 16'd0) begin mp[1] = 1'b1; ml[1] = pl1; end

         chk("rnd_busy", busy, have && e >= g && e < idle_edge);
         chk("rnd_start", tx_start_en, have && e == s_edge);
         chk("rnd_ch", active_ch, m_ch);
         chk("rnd_len", tx_byte_num, m_len);
         chk("rnd_done0", ch0_done, have && e == end_edge && !m_to && !m_ch);
         chk("rnd_done1", ch1_done, have && e == end_edge && !m_to && m_ch);
         chk("rnd_to", timeout_err, have && e == end_edge && m_to);

         ps0 = ($urandom_range(0, 9) == 0);
         pl0 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         ps1 = ($urandom_range(0, 9) == 0);
         pl1 = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         ch0_start = ps0; ch0_byte_num = pl0;
         ch1_start = ps1; ch1_byte_num = pl1;
         tx_req = 1'($urandom_range(0, 1));
         ch0_rd_data = $urandom;
         ch1_rd_data = $urandom;
         busy_now = have && e >= s_edge && e < end_edge;
         if (have && !m_to && e + 1 == end_edge) begin
            tx_done = 1'b1;
         end else if (!busy_now && $urandom_range(0, 15) == 0) begin
            tx_done = 1'b1;
         end
         #1;
         chk("rnd_rd0", ch0_rd_en, tx_req && busy_now && !m_ch);
         chk("rnd_rd1", ch1_rd_en, tx_req && busy_now && m_ch);
         chk("rnd_data", tx_data, m_ch ? ch1_rd_data : ch0_rd_data);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
